// File: rtl/sap_mar_pkg.sv
// Shared definitions for the extended SAP memory address register.
//   mar_state_t : IDLE / COLLECT state of the beat sequencer
//   beats_f     : number of W-bus beats that make up one address
//   idx_w_f     : width of the beat counter (never narrower than 1 bit)
package sap_mar_pkg;

    typedef enum logic {
        MAR_IDLE    = 1'b0,
        MAR_COLLECT = 1'b1
    } mar_state_t;

    function automatic int beats_f(input int addr_w, input int bus_w);
        return addr_w / bus_w;
    endfunction

    function automatic int idx_w_f(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/sap_mar_ext_stager.sv
// Staging register and beat counter for multi-beat address loads.
//   CLK, CLR_bar : clock, async active-low reset
//   i_bus        : one W-bus beat
//   i_strobe     : accept i_bus into the slice selected by the beat counter
//   i_clear      : discard collected beats and restart at the LSB slice
//   o_staged     : staging contents with the current beat merged in, so the
//                  top can commit the full address on the last-beat edge
//   o_last       : the next accepted beat completes the address
module mar_beat_stager
    import sap_mar_pkg::*;
#(
    parameter int BUS_W = 8,
    parameter int BEATS = 2
) (
    input  logic                   CLK,
    input  logic                   CLR_bar,
    input  logic [BUS_W-1:0]       i_bus,
    input  logic                   i_strobe,
    input  logic                   i_clear,
    output logic [BEATS*BUS_W-1:0] o_staged,
    output logic                   o_last
);

    localparam int IDX_W = idx_w_f(BEATS);

    logic [BEATS*BUS_W-1:0] r_stage;
    logic [IDX_W-1:0]       r_idx;
    logic [BEATS*BUS_W-1:0] w_merged;

    for (genvar g = 0; g < BEATS; g++) begin : g_slice
        assign w_merged[g*BUS_W +: BUS_W] =
            (r_idx == IDX_W'(g)) ? i_bus : r_stage[g*BUS_W +: BUS_W];
    end

    // With a single beat the counter sits at 0, which is also the last index.
    assign o_last   = (r_idx == IDX_W'(BEATS-1));
    assign o_staged = w_merged;

    always_ff @(posedge CLK or negedge CLR_bar) begin
        if (!CLR_bar) begin
            r_stage <= '0;
            r_idx   <= '0;
        end else if (i_clear) begin
            r_stage <= '0;
            r_idx   <= '0;
        end else if (i_strobe) begin
            r_stage <= w_merged;
            r_idx   <= o_last ? '0 : r_idx + 1'b1;
        end
    end

endmodule

// File: rtl/sap_mar_ext.sv
// Extended memory address register: full-width load, LSB-first multi-beat
// load from the W bus committed atomically, and increment with wrap pulse.
//   CLK, CLR_bar : clock, async active-low reset
//   Lm_bar       : full-width load from addr_in (highest priority)
//   Lb_bar       : beat load from bus_in
//   Im           : increment committed address (ignored mid-sequence)
//   addr_in      : full-width address source
//   bus_in       : W bus beat
//   mar_output   : committed address to RAM
//   busy         : beat sequence partially collected
//   wrap         : one-cycle pulse after an all-ones -> zero increment
module sap_mar_ext
    import sap_mar_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                BUS_W    = 8,
    parameter logic [ADDR_W-1:0] RST_ADDR = '0
) (
    input  logic              CLK,
    input  logic              CLR_bar,
    input  logic              Lm_bar,
    input  logic              Lb_bar,
    input  logic              Im,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [BUS_W-1:0]  bus_in,
    output logic [ADDR_W-1:0] mar_output,
    output logic              busy,
    output logic              wrap
);

    localparam int BEATS = beats_f(ADDR_W, BUS_W);

    if ((ADDR_W % BUS_W) != 0) begin : g_bad_width
        $error("sap_mar_ext: ADDR_W must be an integer multiple of BUS_W");
    end

    mar_state_t        r_state;
    logic [ADDR_W-1:0] r_mar;
    logic              r_wrap;
    logic [ADDR_W-1:0] w_staged;
    logic              w_last;
    logic              w_strobe;
    logic              w_clear;

    // A full load in the same cycle drops the beat and flushes the stager.
    assign w_clear  = !Lm_bar;
    assign w_strobe = !Lb_bar && Lm_bar;

    mar_beat_stager #(
        .BUS_W (BUS_W),
        .BEATS (BEATS)
    ) u_stager (
        .CLK      (CLK),
        .CLR_bar  (CLR_bar),
        .i_bus    (bus_in),
        .i_strobe (w_strobe),
        .i_clear  (w_clear),
        .o_staged (w_staged),
        .o_last   (w_last)
    );

    always_ff @(posedge CLK or negedge CLR_bar) begin
        if (!CLR_bar) begin
            r_mar   <= RST_ADDR;
            r_wrap  <= 1'b0;
            r_state <= MAR_IDLE;
        end else begin
            r_wrap <= 1'b0;
            if (!Lm_bar) begin
                r_mar   <= addr_in;
                r_state <= MAR_IDLE;
            end else if (!Lb_bar) begin
                if (w_last) begin
                    r_mar   <= w_staged;
                    r_state <= MAR_IDLE;
                end else begin
                    r_state <= MAR_COLLECT;
                end
            end else if (Im && (r_state == MAR_IDLE)) begin
                r_mar  <= r_mar + 1'b1;
                r_wrap <= &r_mar;
            end
        end
    end

    assign mar_output = r_mar;
    assign busy       = (r_state == MAR_COLLECT);
    assign wrap       = r_wrap;

endmodule

// File: tb/tb_sap_mar_ext.sv
module tb_sap_mar_ext;

    logic        CLK = 1'b0;
    logic        CLR_bar = 1'b0;
    logic        Lm_bar = 1'b1;
    logic        Lb_bar = 1'b1;
    logic        Im = 1'b0;
    logic [15:0] addr_in = '0;
    logic [7:0]  bus_in = '0;

    logic [15:0] mar_a;
    logic        busy_a, wrap_a;
    logic [7:0]  mar_b;
    logic        busy_b, wrap_b;

    int checks = 0;
    int failures = 0;

    // reference model state, index 0 = 16/8 instance, 1 = 8/8 instance
    logic [15:0] m_mar[2];
    logic        m_wrap[2];
    logic [7:0]  m_beat[2][4];
    int          m_cnt[2];
    int          m_beats[2] = '{2, 1};
    logic [15:0] m_mask[2]  = '{16'hFFFF, 16'h00FF};

    always #5 CLK = ~CLK;

    sap_mar_ext #(.ADDR_W(16), .BUS_W(8), .RST_ADDR(16'h0000)) dut_a (
        .CLK(CLK), .CLR_bar(CLR_bar), .Lm_bar(Lm_bar), .Lb_bar(Lb_bar), .Im(Im),
        .addr_in(addr_in), .bus_in(bus_in),
        .mar_output(mar_a), .busy(busy_a), .wrap(wrap_a)
    );

    sap_mar_ext #(.ADDR_W(8), .BUS_W(8), .RST_ADDR(8'h00)) dut_b (
        .CLK(CLK), .CLR_bar(CLR_bar), .Lm_bar(Lm_bar), .Lb_bar(Lb_bar), .Im(Im),
        .addr_in(addr_in[7:0]), .bus_in(bus_in),
        .mar_output(mar_b), .busy(busy_b), .wrap(wrap_b)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mar[k]  = '0;
            m_wrap[k] = 1'b0;
            m_cnt[k]  = 0;
        end
    endtask

    // Address register semantics: collected beats kept as a list, the address
    // assembled by weighting beat i with 256**i once the list is full.
    task automatic model_step(input logic lm, input logic lb, input logic im,
                              input logic [15:0] addr, input logic [7:0] bus);
        for (int k = 0; k < 2; k++) begin
            m_wrap[k] = 1'b0;
            if (!lm) begin
                m_mar[k] = addr & m_mask[k];
                m_cnt[k] = 0;
            end else if (!lb) begin
                m_beat[k][m_cnt[k]] = bus;
                m_cnt[k]++;
                if (m_cnt[k] == m_beats[k]) begin
                    int v = 0;
                    for (int i = 0; i < m_beats[k]; i++) v += int'(m_beat[k][i]) * (256 ** i);
                    m_mar[k] = 16'(v);
                    m_cnt[k] = 0;
                end
            end else if (im && m_cnt[k] == 0) begin
                m_wrap[k] = (m_mar[k] == m_mask[k]);
                m_mar[k]  = 16'((int'(m_mar[k]) + 1) % (int'(m_mask[k]) + 1));
            end
        end
    endtask

    task automatic compare_model();
        check("mdl_mar_a",  mar_a,            m_mar[0]);
        check("mdl_busy_a", {15'b0, busy_a},  {15'b0, m_cnt[0] != 0});
        check("mdl_wrap_a", {15'b0, wrap_a},  {15'b0, m_wrap[0]});
        check("mdl_mar_b",  {8'b0, mar_b},    m_mar[1]);
        check("mdl_busy_b", {15'b0, busy_b},  {15'b0, m_cnt[1] != 0});
        check("mdl_wrap_b", {15'b0, wrap_b},  {15'b0, m_wrap[1]});
    endtask

    // Drive inputs just after an edge, advance one edge, compare against model.
    task automatic cyc(input logic lm, input logic lb, input logic im,
                       input logic [15:0] addr, input logic [7:0] bus);
        Lm_bar = lm; Lb_bar = lb; Im = im; addr_in = addr; bus_in = bus;
        @(posedge CLK);
        model_step(lm, lb, im, addr, bus);
        #1;
        compare_model();
    endtask

    initial begin
        model_reset();
        @(posedge CLK); #1;
        CLR_bar = 1'b1;

        // 1: reset mid-sequence acts without a clock edge
        cyc(1'b0, 1'b1, 1'b0, 16'h9999, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000, 8'h77);
        check("pre_rst_busy", {15'b0, busy_a}, 16'h0001);
        #2 CLR_bar = 1'b0;
        #1;
        model_reset();
        check("rst_mar",  mar_a,            16'h0000);
        check("rst_busy", {15'b0, busy_a},  16'h0000);
        check("rst_wrap", {15'b0, wrap_a},  16'h0000);
        @(posedge CLK); #1;
        CLR_bar = 1'b1;

        // 2: full load
        cyc(1'b0, 1'b1, 1'b0, 16'h1234, 8'h00);
        check("full_mar",  mar_a,           16'h1234);
        check("full_busy", {15'b0, busy_a}, 16'h0000);

        // 3: two beats with a gap
        cyc(1'b1, 1'b0, 1'b0, 16'h0000, 8'hCD);
        check("b1_busy", {15'b0, busy_a}, 16'h0001);
        check("b1_hold", mar_a,           16'h1234);
        cyc(1'b1, 1'b1, 1'b0, 16'h0000, 8'h00);
        cyc(1'b1, 1'b1, 1'b0, 16'h0000, 8'h00);
        check("gap_busy", {15'b0, busy_a}, 16'h0001);
        check("gap_hold", mar_a,           16'h1234);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000, 8'hAB);
        check("b2_mar",  mar_a,           16'hABCD);
        check("b2_busy", {15'b0, busy_a}, 16'h0000);

        // 4: abort by simultaneous loads, then restart at LSB
        cyc(1'b1, 1'b0, 1'b0, 16'h0000, 8'h11);
        cyc(1'b0, 1'b0, 1'b0, 16'h0400, 8'h22);
        check("abort_mar",  mar_a,           16'h0400);
        check("abort_busy", {15'b0, busy_a}, 16'h0000);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000, 8'h33);
        check("restart_busy", {15'b0, busy_a}, 16'h0001);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000, 8'h44);
        check("restart_mar", mar_a, 16'h4433);

        // 5: increment with rollover, Im ignored mid-sequence
        cyc(1'b0, 1'b1, 1'b0, 16'hFFFE, 8'h00);
        cyc(1'b1, 1'b1, 1'b1, 16'h0000, 8'h00);
        check("inc1_mar",  mar_a,           16'hFFFF);
        check("inc1_wrap", {15'b0, wrap_a}, 16'h0000);
        check("inc1_mar_b", {8'b0, mar_b},  16'h00FF);
        cyc(1'b1, 1'b1, 1'b1, 16'h0000, 8'h00);
        check("inc2_mar",  mar_a,           16'h0000);
        check("inc2_wrap", {15'b0, wrap_a}, 16'h0001);
        check("inc2_wrap_b", {15'b0, wrap_b}, 16'h0001);
        cyc(1'b1, 1'b1, 1'b1, 16'h0000, 8'h00);
        check("inc3_mar",  mar_a,           16'h0001);
        check("inc3_wrap", {15'b0, wrap_a}, 16'h0000);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000, 8'h10);
        cyc(1'b1, 1'b1, 1'b1, 16'h0000, 8'h00);
        check("coll_inc_mar",  mar_a,           16'h0001);
        check("coll_inc_wrap", {15'b0, wrap_a}, 16'h0000);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000, 8'h20);
        check("coll_done_mar", mar_a, 16'h2010);

        // 6: single-beat instance
        cyc(1'b1, 1'b0, 1'b0, 16'h0000, 8'h5A);
        check("b8_mar",  {8'b0, mar_b},     16'h005A);
        check("b8_busy", {15'b0, busy_b},   16'h0000);

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom_range(0, 7) != 0), ($urandom_range(0, 2) != 0),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom),
                8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
